demux_nbit_stream: RTL and testbench

//  Registered 1-to-4 N-bit stream demultiplexer; inverse of the N-bit 4:1 MUX datapath.

---
 rtl/demux_nbit_stream.sv | 88 ++++++++
 tb/tb_demux_nbit_stream.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/demux_nbit_stream.sv
// Registered 1-to-4 N-bit stream demultiplexer with valid/ready on every channel
// and per-channel saturating delivery counters.

module demux_nbit_stream_ch #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic [N-1:0]  din,
  input  logic          ordy,
  input  logic          cnt_clr,
  output logic [N-1:0]  data,
  output logic          valid,
  output logic [CW-1:0] cnt
);

  logic deliver;
  assign deliver = valid & ordy;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      // a same-edge accept overrides the drain, so the slot stays full with new data
      if (acc) begin
        data  <= din;
        valid <= 1'b1;
      end else if (ordy) begin
        valid <= 1'b0;
      end
      if (cnt_clr)
        cnt <= '0;
      else if (deliver && (cnt != {CW{1'b1}}))
        cnt <= cnt + CW'(1);
    end
  end

endmodule

module demux_nbit_stream #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_data,
  input  logic [1:0]      in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [4*N-1:0]  out_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  input  logic            cnt_clr,
  output logic [4*CW-1:0] cnt
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] acc;

  // Ready only looks at the selected channel, so a stalled channel never blocks others.
  assign in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);

  always_comb begin
    acc = '0;
    if (in_valid && in_ready)
      acc[in_sel] = 1'b1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_ch
    demux_nbit_stream_ch #(.N(N), .CW(CW)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .acc     (acc[k]),
      .din     (in_data),
      .ordy    (out_ready[k]),
      .cnt_clr (cnt_clr),
      .data    (out_data[k*N +: N]),
      .valid   (out_valid[k]),
      .cnt     (cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_demux_nbit_stream.sv
// Directed bench for demux_nbit_stream: vector table for reset/route/backpressure,
// hand sequences for streaming, counter saturation/clear and mid-operation reset.

module tb_demux_nbit_stream;

  localparam int N  = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_data;
  logic [1:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [4*N-1:0]  out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic            cnt_clr;
  logic [4*CW-1:0] cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_nbit_stream #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  d;
    logic [1:0]  sel;
    logic        v;
    logic [3:0]  ordy;
    logic        clr;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [15:0] exp_od;
    logic [15:0] od_mask;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] d, input logic [1:0] s,
                       input logic v, input logic [3:0] ordy, input logic clr);
    rst = r; in_data = d; in_sel = s; in_valid = v; out_ready = ordy; cnt_clr = clr;
  endtask

  // advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0);

    //          rst  d     sel   v     ordy   clr   rdy   ov     od        mask      cnt
    vecs[0]  = '{1'b1, 4'hF, 2'd0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'hFFFF, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 2'd3, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 16'h0000, 16'hFFFF, 32'h0};
    vecs[2]  = '{1'b0, 4'h2, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h1, 16'h0002, 16'h000F, 32'h0};
    vecs[3]  = '{1'b0, 4'h6, 2'd1, 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 16'h0062, 16'h00FF, 32'h0};
    vecs[4]  = '{1'b0, 4'hA, 2'd2, 1'b1, 4'h0, 1'b0, 1'b1, 4'h7, 16'h0A62, 16'h0FFF, 32'h0};
    vecs[5]  = '{1'b0, 4'h3, 2'd3, 1'b1, 4'h0, 1'b0, 1'b1, 4'hF, 16'h3A62, 16'hFFFF, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0, 1'b1, 4'hE, 16'h3A60, 16'hFFF0, 32'h1};
    vecs[7]  = '{1'b0, 4'h5, 2'd2, 1'b1, 4'h0, 1'b0, 1'b0, 4'hE, 16'h3A60, 16'hFFF0, 32'h1};
    vecs[8]  = '{1'b0, 4'h5, 2'd0, 1'b1, 4'h0, 1'b0, 1'b1, 4'hF, 16'h3A65, 16'hFFFF, 32'h1};
    vecs[9]  = '{1'b0, 4'h9, 2'd2, 1'b1, 4'h4, 1'b0, 1'b1, 4'hF, 16'h3965, 16'hFFFF, 32'h00010001};
    vecs[10] = '{1'b0, 4'h0, 2'd2, 1'b0, 4'h8, 1'b1, 1'b0, 4'h7, 16'h0965, 16'h0FFF, 32'h0};

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].d, vecs[i].sel, vecs[i].v, vecs[i].ordy, vecs[i].clr);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      step();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d out_data", i), 32'(out_data & vecs[i].od_mask),
          32'(vecs[i].exp_od & vecs[i].od_mask));
      chk($sformatf("vec%0d cnt", i), cnt, vecs[i].exp_cnt);
    end

    // streaming through channel B with all consumers ready
    drive(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b1);
    step();
    chk("flush out_valid", 32'(out_valid), 32'h0);
    chk("flush cnt", cnt, 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'(i + 1), 2'd1, 1'b1, 4'hF, 1'b0);
      #1;
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'h2);
      chk($sformatf("stream%0d data", i), 32'(out_data[7:4]), 32'(i + 1));
    end
    drive(1'b0, 4'h0, 2'd1, 1'b0, 4'hF, 1'b0);
    step();
    chk("stream drained", 32'(out_valid), 32'h0);
    chk("stream cnt", cnt, 32'h0000_0800);

    // 300 deliveries to D must saturate at 255
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 4'(i), 2'd3, 1'b1, 4'h8, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 2'd3, 1'b0, 4'h8, 1'b0);
    step();
    chk("sat cnt", cnt, 32'hFF00_0800);
    drive(1'b0, 4'h7, 2'd3, 1'b1, 4'h8, 1'b0);
    step();
    drive(1'b0, 4'h0, 2'd3, 1'b0, 4'h8, 1'b1);
    step();
    chk("clr vs delivery cnt", cnt, 32'h0);
    chk("clr vs delivery ov", 32'(out_valid), 32'h0);

    // reset while A and C hold words and consumers are ready
    drive(1'b0, 4'hC, 2'd0, 1'b1, 4'h0, 1'b0);
    step();
    drive(1'b0, 4'hD, 2'd2, 1'b1, 4'h0, 1'b0);
    step();
    chk("pre-rst out_valid", 32'(out_valid), 32'h5);
    drive(1'b1, 4'hE, 2'd1, 1'b1, 4'hF, 1'b0);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'h0);
    step();
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst cnt", cnt, 32'h0);
    drive(1'b0, 4'h0, 2'd0, 1'b0, 4'hF, 1'b0);
    step();
    chk("post-rst cnt", cnt, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
